// File: rtl/rob_commit_sched.sv
// rob_commit_sched: commit-side scheduler for the reorder buffer head and the
// store-buffer drain port.
//
// Handshake rule for the drain port: sb_req is a combinational request that
// holds while a ready store waits to retire. A transfer happens in the cycle
// in which sb_req and sb_ack are both high. sb_ack while sb_req is low is
// ignored. A snoop may withdraw sb_req before it is acknowledged.
//
// Optional build macro: ROB_COMMIT_SCHED_PERF_EN adds the saturating
// perf_commit, perf_store_stall and perf_flush counters, each PERF_W bits wide.
module rob_commit_sched #(
   parameter int FLUSH_CYCLES = 3,
   parameter int CNT_W        = 4
`ifdef ROB_COMMIT_SCHED_PERF_EN
   ,
   parameter int PERF_W       = 32
`endif
) (
   input  logic clk,
   input  logic resetn,
   input  logic snoop_hit,
   input  logic head_valid,
   input  logic head_done,
   input  logic head_store,
   input  logic head_bco,
   output logic sb_req,
   input  logic sb_ack,
   output logic en_commit,
   output logic en_commit_store,
   output logic bco_valid,
`ifdef ROB_COMMIT_SCHED_PERF_EN
   output logic [PERF_W-1:0] perf_commit,
   output logic [PERF_W-1:0] perf_store_stall,
   output logic [PERF_W-1:0] perf_flush,
`endif
   output logic flush_busy
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_STORE_WAIT = 2'd1,
      ST_FLUSH      = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             flush_trigger;
   logic             ready;

   assign ready = head_valid & head_done;

   // State register, flush counter and the registered flush outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_RUN;
         cnt        <= '0;
         bco_valid  <= 1'b0;
         flush_busy <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         bco_valid  <= flush_trigger;
         flush_busy <= (state_next == ST_FLUSH);
      end
   end

   // Next-state logic; a snoop overrides everything and (re)opens the window.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      flush_trigger = 1'b0;
      if (snoop_hit) begin
         state_next    = ST_FLUSH;
         cnt_next      = FLUSH_LOAD;
         flush_trigger = 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (ready && !head_store && head_bco) begin
                  state_next    = ST_FLUSH;
                  cnt_next      = FLUSH_LOAD;
                  flush_trigger = 1'b1;
               end else if (ready && head_store && !sb_ack) begin
                  state_next = ST_STORE_WAIT;
               end
            end
            ST_STORE_WAIT: begin
               // Head is held stable by the ROB here, only the ack matters.
               if (sb_ack) begin
                  state_next = ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (cnt == CNT_ONE) begin
                  state_next = ST_RUN;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt - CNT_ONE;
               end
            end
            default: begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Commit and store-request outputs; forced low in reset and on a snoop.
   always_comb begin
      sb_req          = 1'b0;
      en_commit       = 1'b0;
      en_commit_store = 1'b0;
      if (resetn && !snoop_hit) begin
         case (state)
            ST_RUN: begin
               if (ready) begin
                  if (head_store) begin
                     sb_req          = 1'b1;
                     en_commit       = sb_ack;
                     en_commit_store = sb_ack;
                  end else begin
                     en_commit = 1'b1;
                  end
               end
            end
            ST_STORE_WAIT: begin
               sb_req          = 1'b1;
               en_commit       = sb_ack;
               en_commit_store = sb_ack;
            end
            default: begin
               sb_req = 1'b0;
            end
         endcase
      end
   end

`ifdef ROB_COMMIT_SCHED_PERF_EN
   // Saturating event counters: commits, store-wait cycles, flush pulses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_commit      <= '0;
         perf_store_stall <= '0;
         perf_flush       <= '0;
      end else begin
         if (en_commit && (perf_commit != '1)) begin
            perf_commit <= perf_commit + 1'b1;
         end
         if ((state == ST_STORE_WAIT) && (perf_store_stall != '1)) begin
            perf_store_stall <= perf_store_stall + 1'b1;
         end
         if (bco_valid && (perf_flush != '1)) begin
            perf_flush <= perf_flush + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_commit_sched.sv
// tb_rob_commit_sched: directed bench for rob_commit_sched with a reference
// model of the commit rules and literal expectations for the key scenarios.
module tb_rob_commit_sched;

   localparam int FC = 3;

   logic clk;
   logic resetn;
   logic snoop_hit;
   logic head_valid;
   logic head_done;
   logic head_store;
   logic head_bco;
   logic sb_req;
   logic sb_ack;
   logic en_commit;
   logic en_commit_store;
   logic bco_valid;
   logic flush_busy;
`ifdef ROB_COMMIT_SCHED_PERF_EN
   logic [31:0] perf_commit;
   logic [31:0] perf_store_stall;
   logic [31:0] perf_flush;
`endif

   int checks;
   int failures;

   rob_commit_sched #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .snoop_hit       (snoop_hit),
      .head_valid      (head_valid),
      .head_done       (head_done),
      .head_store      (head_store),
      .head_bco        (head_bco),
      .sb_req          (sb_req),
      .sb_ack          (sb_ack),
      .en_commit       (en_commit),
      .en_commit_store (en_commit_store),
      .bco_valid       (bco_valid),
`ifdef ROB_COMMIT_SCHED_PERF_EN
      .perf_commit     (perf_commit),
      .perf_store_stall(perf_store_stall),
      .perf_flush      (perf_flush),
`endif
      .flush_busy      (flush_busy)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining blocked cycles, pending store, pulse owed.
   int     m_left;
   bit     m_pend;
   bit     m_pulse;
   bit     m_live = 1'b0;
   int     m_commits;
   int     m_stalls;
   int     m_flushes;

   // Returns {sb_req, en_commit, en_commit_store} demanded by the rules.
   function automatic logic [2:0] model_comb();
      logic rdy;
      rdy = head_valid & head_done;
      if (!resetn || snoop_hit || m_left > 0) return 3'b000;
      if (m_pend) return {1'b1, sb_ack, sb_ack};
      if (!rdy) return 3'b000;
      if (head_store) return {1'b1, sb_ack, sb_ack};
      return 3'b010;
   endfunction

   always @(posedge clk) begin
      logic [2:0] e;
      logic       rdy;
      if (!resetn) begin
         m_left = 0; m_pend = 0; m_pulse = 0; m_live = 1'b1;
         m_commits = 0; m_stalls = 0; m_flushes = 0;
      end else if (m_live) begin
         e   = model_comb();
         rdy = head_valid & head_done;
         if (e[1]) m_commits++;
         if (m_pend) m_stalls++;
         if (m_pulse) m_flushes++;
         m_pulse = 1'b0;
         if (snoop_hit) begin
            m_left = FC; m_pend = 0; m_pulse = 1'b1;
         end else if (m_left > 0) begin
            m_left--;
         end else if (m_pend) begin
            if (sb_ack) m_pend = 0;
         end else if (rdy && head_store) begin
            if (!sb_ack) m_pend = 1;
         end else if (rdy && head_bco) begin
            m_left = FC; m_pulse = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      logic [2:0] e;
      if (m_live) begin
         e = model_comb();
         chk("m_sb_req", {31'd0, sb_req}, {31'd0, e[2]});
         chk("m_en_commit", {31'd0, en_commit}, {31'd0, e[1]});
         chk("m_en_commit_store", {31'd0, en_commit_store}, {31'd0, e[0]});
         chk("m_bco_valid", {31'd0, bco_valid}, {31'd0, m_pulse});
         chk("m_flush_busy", {31'd0, flush_busy}, {31'd0, (m_left > 0)});
`ifdef ROB_COMMIT_SCHED_PERF_EN
         chk("m_perf_commit", perf_commit, m_commits);
         chk("m_perf_store_stall", perf_store_stall, m_stalls);
         chk("m_perf_flush", perf_flush, m_flushes);
`endif
      end
   end

   // Driver: apply one cycle of inputs just after the edge, return at negedge.
   task automatic drive(input logic rn, input logic v, input logic d, input logic st,
                        input logic bco, input logic ack, input logic sn);
      @(posedge clk);
      #1;
      resetn = rn; head_valid = v; head_done = d; head_store = st;
      head_bco = bco; sb_ack = ack; snoop_hit = sn;
      @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0;
      resetn = 1'b0; head_valid = 1'b0; head_done = 1'b0; head_store = 1'b0;
      head_bco = 1'b0; sb_ack = 1'b0; snoop_hit = 1'b0;

      // Reset holds comb outputs low even with a ready, acked store head
      drive(0, 1, 1, 1, 0, 1, 0);
      drive(0, 1, 1, 1, 0, 1, 0);
      chk("rst_en_commit", en_commit, 0);
      chk("rst_sb_req", sb_req, 0);
      chk("rst_bco_valid", bco_valid, 0);
      chk("rst_flush_busy", flush_busy, 0);

      // Non-store retire for four cycles
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0, 0, 0, 0);
         chk("ns_en_commit", en_commit, 1);
         chk("ns_sb_req", sb_req, 0);
         chk("ns_bco_valid", bco_valid, 0);
      end

      // sb_ack without a request is ignored
      drive(1, 0, 0, 0, 0, 1, 0);
      chk("stray_ack_commit", en_commit, 0);

      // Store fast path, then still in RUN
      drive(1, 1, 1, 1, 0, 1, 0);
      chk("fast_en_commit", en_commit, 1);
      chk("fast_en_store", en_commit_store, 1);
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("fast_after_commit", en_commit, 1);

      // Store stall: three unacked cycles then ack
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 1, 0, 0, 0);
         chk("stall_sb_req", sb_req, 1);
         chk("stall_no_commit", en_commit, 0);
      end
      drive(1, 1, 1, 1, 0, 1, 0);
      chk("stall_sb_req4", sb_req, 1);
      chk("stall_commit4", en_commit, 1);
      chk("stall_store4", en_commit_store, 1);

      // Store carrying head_bco retires as a plain store: no pulse afterwards
      drive(1, 1, 1, 1, 1, 1, 0);
      chk("stbco_commit", en_commit, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("stbco_no_pulse", bco_valid, 0);
      chk("stbco_no_busy", flush_busy, 0);

      // Branch correction: commit, pulse, three blocked cycles, resume
      drive(1, 1, 1, 0, 1, 0, 0);
      chk("bco_c0_commit", en_commit, 1);
      chk("bco_c0_pulse", bco_valid, 0);
      for (int i = 1; i <= 3; i++) begin
         drive(1, 1, 1, 0, 0, 0, 0);
         chk("bco_blk_commit", en_commit, 0);
         chk("bco_blk_busy", flush_busy, 1);
         chk("bco_blk_pulse", bco_valid, (i == 1));
      end
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("bco_c4_commit", en_commit, 1);
      chk("bco_c4_busy", flush_busy, 0);

      // Snoop during STORE_WAIT, second snoop in blocked cycle 2
      drive(1, 1, 1, 1, 0, 0, 0);
      chk("sw_req", sb_req, 1);
      drive(1, 1, 1, 1, 0, 0, 1);
      chk("sw_snoop_req", sb_req, 0);
      chk("sw_snoop_commit", en_commit, 0);
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("sw_b1_pulse", bco_valid, 1);
      chk("sw_b1_busy", flush_busy, 1);
      drive(1, 1, 1, 0, 0, 0, 1);
      chk("sw_b2_pulse", bco_valid, 0);
      chk("sw_b2_commit", en_commit, 0);
      for (int i = 1; i <= 3; i++) begin
         drive(1, 1, 1, 0, 0, 0, 0);
         chk("sw_r_pulse", bco_valid, (i == 1));
         chk("sw_r_busy", flush_busy, 1);
         chk("sw_r_commit", en_commit, 0);
      end
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("sw_resume", en_commit, 1);

      // bco commit and snoop together: one pulse, no commit
      drive(1, 1, 1, 0, 1, 0, 1);
      chk("both_commit", en_commit, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("both_pulse1", bco_valid, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("both_pulse2", bco_valid, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("both_done", flush_busy, 0);

      // Reset in blocked cycle 2 of a snoop window
      drive(1, 1, 1, 0, 0, 0, 1);
      drive(1, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      chk("rmid_commit", en_commit, 0);
      chk("rmid_busy", flush_busy, 1);
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("rpost_busy", flush_busy, 0);
      chk("rpost_pulse", bco_valid, 0);
      chk("rpost_commit", en_commit, 1);
`ifdef ROB_COMMIT_SCHED_PERF_EN
      chk("rpost_perf_commit", perf_commit, 0);
      chk("rpost_perf_stall", perf_store_stall, 0);
      chk("rpost_perf_flush", perf_flush, 0);
`endif

      drive(1, 0, 0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
